// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, opcode names and scheduler state encoding for the ALU arbiter
package alu_pkg;
  localparam int CMD_W = 12;
  localparam int DATA_W = 32;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_LD  = 3'b101,
    OP_ST  = 3'b110,
    OP_CAS = 3'b111
  } op_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} sched_state_t;
  function automatic logic [2:0] wrap_inc(input logic [2:0] v, input int n);
    return (int'(v) == n - 1) ? 3'd0 : v + 3'd1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotating-priority encoder, picks the requester closest at or above ptr (mod N)
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  output logic         valid,
  output logic [2:0]   idx
);
  always_comb begin
    int best, d;
    valid = 1'b0;
    idx = '0;
    best = N;
    for (int j = 0; j < N; j++) begin
      d = (j >= int'(ptr)) ? j - int'(ptr) : j + N - int'(ptr);
      if (req[j] && d < best) begin
        best = d;
        idx = 3'(j);
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: round-robin sharing of one ALU controller among N_REQ requesters with optional grant lock.
// Define ALU_ARB_TIMEOUT_EN to abort a WAIT that exceeds TIMEOUT cycles with rsp_err.
module alu_rr_scheduler
  import alu_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int CMD_W   = alu_pkg::CMD_W,
  parameter int DATA_W  = alu_pkg::DATA_W,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       lock,
  input  logic [N_REQ*CMD_W-1:0] cmd,
  output logic [N_REQ-1:0]       ack,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   rsp_z,
  output logic                   rsp_err,
  output logic [2:0]             gnt_id,
  output logic [CMD_W-1:0]       alu_cmd,
  output logic                   alu_syscall,
  input  logic                   alu_done,
  input  logic [DATA_W-1:0]      alu_y,
  input  logic                   alu_z
);
  sched_state_t state;
  logic [2:0] ptr, pick_idx, nxt;
  logic locked, pick_valid, own, go;
  logic [7:0] req_x, lock_x;
  logic [CMD_W-1:0] cmd_a [8];
  rr_pick #(.N(N_REQ)) u_pick (.req(req), .ptr(ptr), .valid(pick_valid), .idx(pick_idx));
  always_comb begin
    for (int i = 0; i < 8; i++) cmd_a[i] = '0;
    for (int i = 0; i < N_REQ; i++) cmd_a[i] = cmd[i*CMD_W +: CMD_W];
    req_x = 8'(req);
    lock_x = 8'(lock);
    own = locked && req_x[gnt_id];
    go = own || (!locked && pick_valid) || (locked && !own && pick_valid);
    nxt = own ? gnt_id : pick_idx;
  end
`ifdef ALU_ARB_TIMEOUT_EN
  logic [$clog2(TIMEOUT+1)-1:0] cnt;
`else
  assign rsp_err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      locked <= 1'b0;
      ack <= '0;
      alu_syscall <= 1'b0;
      alu_cmd <= '0;
      rsp_data <= '0;
      rsp_z <= 1'b0;
      gnt_id <= '0;
`ifdef ALU_ARB_TIMEOUT_EN
      rsp_err <= 1'b0;
      cnt <= '0;
`endif
    end else begin
      ack <= '0;
      alu_syscall <= 1'b0;
      case (state)
        IDLE: begin
          if (!own) locked <= 1'b0;
          if (go) begin
            gnt_id <= nxt;
            alu_cmd <= cmd_a[nxt];
            alu_syscall <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
`ifdef ALU_ARB_TIMEOUT_EN
          cnt <= '0;
`endif
        end
        WAIT: begin
          if (alu_done) begin
            rsp_data <= alu_y;
            rsp_z <= alu_z;
            ack <= N_REQ'(1) << gnt_id;
            state <= RESP;
`ifdef ALU_ARB_TIMEOUT_EN
            rsp_err <= 1'b0;
          end else if (int'(cnt) == TIMEOUT - 1) begin
            rsp_data <= '0;
            rsp_z <= 1'b0;
            rsp_err <= 1'b1;
            ack <= N_REQ'(1) << gnt_id;
            state <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
`endif
          end
        end
        default: begin
          ptr <= wrap_inc(gnt_id, N_REQ);
`ifdef ALU_ARB_TIMEOUT_EN
          locked <= lock_x[gnt_id] && !rsp_err;
`else
          locked <= lock_x[gnt_id];
`endif
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
